afe_responder: RTL and testbench
================================

AFE_RESPONDER -- requirements
Module: afe_responder

Interface
REQ-001 Parameter: none; all behaviour fixed by this document.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 c1  input  2  phase code 1 from controller.
REQ-005 c2  input  2  phase code 2 from controller.
REQ-006 diode  input  8  diode-select word from controller.
REQ-007 res_n  input  1  controller reset-switch control.
REQ-008 coarse  input  1  1 = coarse search on ib, 0 = fine search on ibf.
REQ-009 ib  input  8  coarse bias code under test.
REQ-010 ibf  input  8  fine bias code under test.
REQ-011 target_c  input  8  coarse code the emulated front end balances at.
REQ-012 target_f  input  8  fine code the emulated front end balances at.
REQ-013 cmp_o  output  1  registered comparator decision; 1 = code too high.
REQ-014 phase_err  output  1  sticky protocol-violation flag.
REQ-015 cmp_count  output  8  number of compare windows entered, wraps.
REQ-016 last_code  output  8  code (ib or ibf) used by the most recent evaluation.

Function
REQ-017 Phase FSM, one state per cycle, with states IDLE, SMALL, GAP1, BIG, GAP2, HOLD; (c1,c2) is sampled each cycle.
REQ-018 IDLE: (2,0) -> SMALL; (0,0) stays in IDLE; any other pair -> error.
REQ-019 SMALL: (2,0) stays; (0,0) -> GAP1; other -> error.
REQ-020 GAP1: (0,0) stays; (0,2) -> BIG; other -> error.
REQ-021 BIG: (0,2) stays; (0,0) -> GAP2 and evaluates (REQ-024); other -> error.
REQ-022 GAP2: (0,0) stays; (1,1) -> HOLD and cmp_count increments by 1, wrapping 255 -> 0; other -> error.
REQ-023 HOLD: (1,1) stays; (2,0) -> SMALL; other -> error.
REQ-024 Evaluation happens on the BIG -> GAP2 edge:
  - cmp_o <= (coarse ? ib > target_c : ibf > target_f), unsigned compare.
  - Equal code gives cmp_o = 0.
  - last_code <= the selected code.
REQ-025 Timing: cmp_o is valid from the cycle after evaluation and holds until the next evaluation, so it is stable throughout GAP2 and HOLD.
REQ-026 cmp_o shall depend only on registered state; there is no combinational path from any input to cmp_o.
REQ-027 Entry check into SMALL: diode must equal 8'h01 and res_n must equal 1 in the same cycle, else error.
REQ-028 Entry check into BIG: diode must equal 8'hFF and res_n must equal 0 in the same cycle, else error.
REQ-029 Error action: phase_err <= 1, FSM -> IDLE in the same edge, and no evaluation or count update on that edge.
REQ-030 phase_err is sticky and is cleared only by reset_n.
REQ-031 An error detected while already in IDLE keeps the FSM in IDLE and sets phase_err.
REQ-032 An entry-check failure wins over a legal (c1,c2) transition.
REQ-033 Inputs ib, ibf, target_c, target_f and coarse changing outside the evaluation edge have no effect.

Reset
REQ-034 While reset_n = 0:
  - FSM = IDLE.
  - cmp_o = 0.
  - phase_err = 0.
  - cmp_count = 8'h00.
  - last_code = 8'h00.
REQ-035 Reset takes effect immediately and asynchronously, including mid-sequence.
REQ-036 Release of reset_n is synchronised to clk; the first active update occurs on the second rising edge after deassertion.
REQ-037 A window interrupted by reset is discarded: no count update and no evaluation.

Verification
REQ-038 Legal window:
  - Stimulus: coarse = 1, ib = 8'h90, target_c = 8'h5A; drive (2,0) with diode = 01 and res_n = 1; then (0,0); then (0,2) with diode = FF and res_n = 0; then (0,0); then (1,1).
  - Response: cmp_o = 1 in the GAP2 cycle, last_code = 8'h90, cmp_count = 1, phase_err = 0.
REQ-039 Closed loop with the bias-search controller:
  - Stimulus: target_c = 8'h5A, target_f = 8'h33.
  - Response: after 8 coarse windows ib = 8'h5A; after 8 fine windows ibf = 8'h33; thereafter ibf dithers between 8'h33 and 8'h34; phase_err stays 0.
REQ-040 Equality: coarse = 0, ibf = target_f = 8'h80 -> cmp_o = 0 after evaluation.
REQ-041 Protocol errors:
  - (1,1) driven while in GAP1 -> phase_err = 1, FSM = IDLE, cmp_count unchanged.
  - Separately, diode = 8'h03 at SMALL entry -> phase_err = 1.
REQ-042 Wrap and reset:
  - 256 legal windows -> cmp_count = 8'h00.
  - reset_n pulsed low during BIG -> all outputs return to reset values immediately; the next legal window counts as 1.

Source files
------------

// File: rtl/afe_responder_if.sv
// Controller <-> emulated analog front end signal bundle.
// The controller (master) drives phase codes, switch controls and the code under
// test; the responder (slave) returns the comparator decision and status.
interface afe_responder_if;
  logic [1:0] c1;
  logic [1:0] c2;
  logic [7:0] diode;
  logic       res_n;
  logic       coarse;
  logic [7:0] ib;
  logic [7:0] ibf;
  logic [7:0] target_c;
  logic [7:0] target_f;
  logic       cmp_o;
  logic       phase_err;
  logic [7:0] cmp_count;
  logic [7:0] last_code;

  modport master (
    output c1, c2, diode, res_n, coarse, ib, ibf, target_c, target_f,
    input  cmp_o, phase_err, cmp_count, last_code
  );

  modport slave (
    input  c1, c2, diode, res_n, coarse, ib, ibf, target_c, target_f,
    output cmp_o, phase_err, cmp_count, last_code
  );
endinterface

// File: rtl/afe_responder.sv
// Emulated analog front end for a bias-search controller.
// Tracks the controller's phase protocol (small/gap/big/gap/hold), checks the
// switch settings on phase entry, and produces a registered comparator decision
// for the code under test against a fixed balance point.
module afe_responder (
  input logic            clk,
  input logic            reset_n,
  afe_responder_if.slave afe
);

  typedef enum logic [2:0] {
    StIdle,
    StSmall,
    StGap1,
    StBig,
    StGap2,
    StHold
  } state_e;

  state_e     state_q, state_d;
  logic       en_q;
  logic       cmp_q, cmp_d;
  logic       err_q, err_d;
  logic [7:0] count_q, count_d;
  logic [7:0] last_q, last_d;

  // Phase-code pair decode
  logic p00, p20, p02, p11;
  // Switch settings required when entering the small and big phases
  logic small_ok, big_ok;

  assign p00 = (afe.c1 == 2'd0) && (afe.c2 == 2'd0);
  assign p20 = (afe.c1 == 2'd2) && (afe.c2 == 2'd0);
  assign p02 = (afe.c1 == 2'd0) && (afe.c2 == 2'd2);
  assign p11 = (afe.c1 == 2'd1) && (afe.c2 == 2'd1);

  assign small_ok = (afe.diode == 8'h01) && afe.res_n;
  assign big_ok   = (afe.diode == 8'hFF) && !afe.res_n;

  logic       error;
  logic       eval;
  logic       bump;
  logic [7:0] sel_code;
  logic [7:0] sel_tgt;

  // Reset release: the first edge after deassertion only arms en_q, so state
  // first moves on the second rising edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q <= 1'b0;
    end else begin
      en_q <= 1'b1;
    end
  end

  // Next-state, protocol checking, evaluation and window counting
  always_comb begin
    state_d  = state_q;
    cmp_d    = cmp_q;
    err_d    = err_q;
    count_d  = count_q;
    last_d   = last_q;
    error    = 1'b0;
    eval     = 1'b0;
    bump     = 1'b0;
    sel_code = afe.coarse ? afe.ib : afe.ibf;
    sel_tgt  = afe.coarse ? afe.target_c : afe.target_f;

    case (state_q)
      StIdle: begin
        if (p20) begin
          if (small_ok) state_d = StSmall;
          else          error   = 1'b1;
        end else if (!p00) begin
          error = 1'b1;
        end
      end
      StSmall: begin
        if (p00)       state_d = StGap1;
        else if (!p20) error   = 1'b1;
      end
      StGap1: begin
        if (p02) begin
          if (big_ok) state_d = StBig;
          else        error   = 1'b1;
        end else if (!p00) begin
          error = 1'b1;
        end
      end
      StBig: begin
        if (p00) begin
          state_d = StGap2;
          eval    = 1'b1;
        end else if (!p02) begin
          error = 1'b1;
        end
      end
      StGap2: begin
        if (p11) begin
          state_d = StHold;
          bump    = 1'b1;
        end else if (!p00) begin
          error = 1'b1;
        end
      end
      StHold: begin
        if (p20) begin
          if (small_ok) state_d = StSmall;
          else          error   = 1'b1;
        end else if (!p11) begin
          error = 1'b1;
        end
      end
      default: error = 1'b1;
    endcase

    // An error aborts the window: back to idle with no evaluation or count
    if (error) begin
      state_d = StIdle;
      err_d   = 1'b1;
    end else begin
      if (eval) begin
        cmp_d  = sel_code > sel_tgt;
        last_d = sel_code;
      end
      if (bump) begin
        count_d = count_q + 8'd1;
      end
    end
  end

  // State and output registers; held until reset release has been synchronised
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cmp_q   <= 1'b0;
      err_q   <= 1'b0;
      count_q <= 8'h00;
      last_q  <= 8'h00;
    end else if (en_q) begin
      state_q <= state_d;
      cmp_q   <= cmp_d;
      err_q   <= err_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign afe.cmp_o     = cmp_q;
  assign afe.phase_err = err_q;
  assign afe.cmp_count = count_q;
  assign afe.last_code = last_q;

endmodule

// File: tb/tb_afe_responder.sv
// Directed bench for afe_responder: reset behaviour, legal windows, equality,
// closed-loop bias search, protocol errors, count wrap and mid-window reset.
module tb_afe_responder;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  afe_responder_if afe ();

  afe_responder u_dut (
    .clk    (clk),
    .reset_n(reset_n),
    .afe    (afe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete (observed=timeout required=finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of controller outputs, then sample 1 time unit after the edge
  task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic [7:0] d,
                       input logic r);
    afe.c1    = a;
    afe.c2    = b;
    afe.diode = d;
    afe.res_n = r;
    @(posedge clk);
    #1;
  endtask

  // One legal compare window; returns cmp_o as seen in the GAP2 cycle
  task automatic window(input logic crs, input logic [7:0] code, output logic cmp_seen);
    afe.coarse = crs;
    if (crs) afe.ib = code;
    else     afe.ibf = code;
    drive(2'd2, 2'd0, 8'h01, 1'b1);
    drive(2'd0, 2'd0, 8'h01, 1'b1);
    drive(2'd0, 2'd2, 8'hFF, 1'b0);
    drive(2'd0, 2'd0, 8'hFF, 1'b0);
    cmp_seen = afe.cmp_o;
    drive(2'd1, 2'd1, 8'h00, 1'b0);
  endtask

  // Pulse reset between edges, then give two idle edges for release
  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("rst_pulse_err", {7'd0, afe.phase_err}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    drive(2'd0, 2'd0, 8'h00, 1'b0);
    drive(2'd0, 2'd0, 8'h00, 1'b0);
  endtask

  initial begin
    logic       c;
    logic [7:0] code;
    logic [7:0] exp;

    total        = 0;
    bad          = 0;
    reset_n      = 1'b0;
    afe.c1       = 2'd0;
    afe.c2       = 2'd0;
    afe.diode    = 8'h00;
    afe.res_n    = 1'b0;
    afe.coarse   = 1'b1;
    afe.ib       = 8'h00;
    afe.ibf      = 8'h00;
    afe.target_c = 8'h5A;
    afe.target_f = 8'h33;

    // Reset state
    @(posedge clk);
    #1;
    check("reset_cmp", {7'd0, afe.cmp_o}, 8'h00);
    check("reset_err", {7'd0, afe.phase_err}, 8'h00);
    check("reset_count", afe.cmp_count, 8'h00);
    check("reset_last", afe.last_code, 8'h00);

    // First edge after release is ignored, second is live
    @(negedge clk);
    reset_n = 1'b1;
    drive(2'd1, 2'd1, 8'h00, 1'b0);
    check("release_edge1_ignored", {7'd0, afe.phase_err}, 8'h00);
    drive(2'd1, 2'd1, 8'h00, 1'b0);
    check("release_edge2_live", {7'd0, afe.phase_err}, 8'h01);
    pulse_reset();

    // Legal coarse window: 0x90 > 0x5A
    window(1'b1, 8'h90, c);
    check("legal_cmp_gap2", {7'd0, c}, 8'h01);
    check("legal_last", afe.last_code, 8'h90);
    check("legal_count", afe.cmp_count, 8'h01);
    check("legal_err", {7'd0, afe.phase_err}, 8'h00);

    // Code/target changes outside the evaluation edge are ignored
    afe.ib       = 8'h00;
    afe.target_c = 8'hFF;
    afe.coarse   = 1'b0;
    drive(2'd1, 2'd1, 8'h00, 1'b0);
    check("hold_cmp_stable", {7'd0, afe.cmp_o}, 8'h01);
    check("hold_last_stable", afe.last_code, 8'h90);
    afe.target_c = 8'h5A;

    // Fine equality gives 0
    afe.target_f = 8'h80;
    window(1'b0, 8'h80, c);
    check("equal_cmp", {7'd0, c}, 8'h00);
    check("equal_last", afe.last_code, 8'h80);
    check("equal_count", afe.cmp_count, 8'h02);

    // Closed-loop successive approximation, coarse then fine, then tracking
    afe.target_c = 8'h5A;
    afe.target_f = 8'h33;
    code = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      code[b] = 1'b1;
      window(1'b1, code, c);
      if (c) code[b] = 1'b0;
    end
    afe.ib = code;
    check("search_coarse", code, 8'h5A);
    code = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      code[b] = 1'b1;
      window(1'b0, code, c);
      if (c) code[b] = 1'b0;
    end
    check("search_fine", code, 8'h33);
    for (int i = 0; i < 6; i++) begin
      window(1'b0, code, c);
      code = c ? code - 8'd1 : code + 8'd1;
      exp  = (i % 2 == 0) ? 8'h34 : 8'h33;
      check("dither", code, exp);
    end
    check("loop_err", {7'd0, afe.phase_err}, 8'h00);
    check("loop_count", afe.cmp_count, 8'd24);

    // (1,1) in GAP1: error, no count, back to idle
    drive(2'd2, 2'd0, 8'h01, 1'b1);
    drive(2'd0, 2'd0, 8'h01, 1'b1);
    drive(2'd1, 2'd1, 8'h00, 1'b0);
    check("gap1_err", {7'd0, afe.phase_err}, 8'h01);
    check("gap1_count", afe.cmp_count, 8'd24);
    drive(2'd0, 2'd0, 8'h00, 1'b0);
    window(1'b1, 8'hFF, c);
    check("after_err_cmp", {7'd0, c}, 8'h01);
    check("after_err_last", afe.last_code, 8'hFF);
    check("after_err_count", afe.cmp_count, 8'd25);
    check("err_sticky", {7'd0, afe.phase_err}, 8'h01);

    // Bad diode word on SMALL entry
    pulse_reset();
    drive(2'd2, 2'd0, 8'h03, 1'b1);
    check("small_entry_diode", {7'd0, afe.phase_err}, 8'h01);

    // res_n high on BIG entry
    pulse_reset();
    drive(2'd2, 2'd0, 8'h01, 1'b1);
    drive(2'd0, 2'd0, 8'h01, 1'b1);
    drive(2'd0, 2'd2, 8'hFF, 1'b1);
    check("big_entry_resn", {7'd0, afe.phase_err}, 8'h01);
    drive(2'd0, 2'd0, 8'hFF, 1'b0);
    drive(2'd1, 2'd1, 8'h00, 1'b0);
    check("big_entry_count", afe.cmp_count, 8'h00);

    // Count wrap
    pulse_reset();
    afe.target_c = 8'h5A;
    for (int i = 0; i < 255; i++) window(1'b1, 8'h90, c);
    check("count_255", afe.cmp_count, 8'hFF);
    window(1'b1, 8'h90, c);
    check("count_wrap", afe.cmp_count, 8'h00);
    window(1'b1, 8'h90, c);
    check("count_after_wrap", afe.cmp_count, 8'h01);

    // Reset during BIG
    drive(2'd2, 2'd0, 8'h01, 1'b1);
    drive(2'd0, 2'd0, 8'h01, 1'b1);
    drive(2'd0, 2'd2, 8'hFF, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_cmp", {7'd0, afe.cmp_o}, 8'h00);
    check("midrst_err", {7'd0, afe.phase_err}, 8'h00);
    check("midrst_count", afe.cmp_count, 8'h00);
    check("midrst_last", afe.last_code, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    drive(2'd0, 2'd0, 8'h00, 1'b0);
    drive(2'd0, 2'd0, 8'h00, 1'b0);
    window(1'b1, 8'h20, c);
    check("midrst_next_count", afe.cmp_count, 8'h01);
    check("midrst_next_cmp", {7'd0, c}, 8'h00);
    check("midrst_next_last", afe.last_code, 8'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
